// File: rtl/icache_setassoc.sv
// icache_setassoc: N-way set-associative, multithreaded I-cache with per-set miss tracking,
// thread stall listeners and same-cycle fill bypass. Define ICACHE_PLRU_EN for tree pseudo-LRU.
module icache_setassoc #(
    parameter int  N_WAYS     = 2,
    parameter int  N_SETS     = 4,
    parameter int  N_THREADS  = 4,
    parameter int  LINE_WORDS = 4,
    parameter int  WORD_W     = 32,
    parameter int  ADDR_W     = 20,
    localparam int TH_W       = (N_THREADS > 1) ? $clog2(N_THREADS) : 1,
    localparam int LINE_W     = LINE_WORDS * WORD_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [TH_W-1:0]      thread,
    input  logic [ADDR_W-1:0]    paddr,
    input  logic                 itlb_miss,
    output logic                 miss,
    output logic [WORD_W-1:0]    data,
    input  logic                 mem_rec_en,
    input  logic [ADDR_W-1:0]    mem_rec_addr,
    input  logic [LINE_W-1:0]    mem_rec_cacheline,
    output logic                 mem_req_ren,
    output logic [ADDR_W-1:0]    mem_req_addr,
    output logic [N_THREADS-1:0] stalled
);
    localparam int OFF_B = $clog2(LINE_W / 8);
    localparam int WS_B  = $clog2(LINE_WORDS);
    localparam int WS_W  = (WS_B > 0) ? WS_B : 1;
    localparam int IDX_B = $clog2(N_SETS);
    localparam int IDX_W = (IDX_B > 0) ? IDX_B : 1;
    localparam int TAG_W = ADDR_W - OFF_B - IDX_B;
    localparam int LVL   = $clog2(N_WAYS);
    localparam int WAY_W = (LVL > 0) ? LVL : 1;
`ifdef ICACHE_PLRU_EN
    localparam int REP_W = (N_WAYS > 1) ? N_WAYS - 1 : 1;

    // Heap-ordered tree: node n keeps its bit at n-1; a 0 steers the victim toward lower ways.
    function automatic logic [REP_W-1:0] rep_touch(input logic [REP_W-1:0] r, input logic [WAY_W-1:0] w);
        int node;
        logic [REP_W-1:0] nr;
        nr = r;
        node = 1;
        for (int l = LVL - 1; l >= 0; l--) begin
            nr[node-1] = ~w[l];
            node = 2 * node + int'(w[l]);
        end
        return nr;
    endfunction

    function automatic logic [WAY_W-1:0] rep_victim(input logic [REP_W-1:0] r);
        int node;
        node = 1;
        for (int l = 0; l < LVL; l++) node = 2 * node + int'(r[node-1]);
        return WAY_W'(node - N_WAYS);
    endfunction
`else
    localparam int REP_W = WAY_W;
`endif

    logic [N_WAYS-1:0] valid_q   [N_SETS];
    logic [TAG_W-1:0]  tag_q     [N_SETS][N_WAYS];
    logic [LINE_W-1:0] line_q    [N_SETS][N_WAYS];
    logic [N_SETS-1:0] pend_q;
    logic [TAG_W-1:0]  req_tag_q [N_SETS];
    logic [WAY_W-1:0]  req_way_q [N_SETS];
    logic [REP_W-1:0]  rep_q     [N_SETS];
    logic [IDX_W-1:0]  lis_set_q [N_THREADS];

    logic [IDX_W-1:0]  l_idx, f_idx;
    logic [TAG_W-1:0]  l_tag, f_tag;
    logic [WS_W-1:0]   wsel;
    logic [WAY_W-1:0]  f_way, victim;
    logic              fill_ok, same, e_pend, hit, fw, found;
    logic [N_WAYS-1:0] e_valid, hit_vec;
    logic [LINE_W-1:0] wline;
    logic [WORD_W-1:0] hit_word;
    logic [REP_W-1:0]  f_rep, e_rep;
`ifdef ICACHE_PLRU_EN
    logic [WAY_W-1:0]  hit_way;
    logic [REP_W-1:0]  h_rep;
`endif

    assign l_idx = (IDX_B > 0) ? paddr[OFF_B +: IDX_W] : '0;
    assign f_idx = (IDX_B > 0) ? mem_rec_addr[OFF_B +: IDX_W] : '0;
    assign l_tag = paddr[ADDR_W-1 -: TAG_W];
    assign f_tag = mem_rec_addr[ADDR_W-1 -: TAG_W];
    assign wsel  = (WS_B > 0) ? paddr[OFF_B-1 -: WS_W] : '0;
    assign f_way = req_way_q[f_idx];

    logic unused_ok;
    assign unused_ok = ^{paddr[OFF_B-WS_B-1:0], mem_rec_addr[OFF_B-1:0]};

    // The lookup sees its set as it will be after a matching fill; that gives the bypass for free.
    always_comb begin
        fill_ok  = mem_rec_en && pend_q[f_idx] && (req_tag_q[f_idx] == f_tag);
        same     = fill_ok && (f_idx == l_idx);
        e_pend   = pend_q[l_idx] && !same;
        e_valid  = '0;
        hit_vec  = '0;
        hit_word = '0;
        fw       = 1'b0;
        wline    = '0;
        for (int w = 0; w < N_WAYS; w++) begin
            fw         = same && (f_way == WAY_W'(w));
            wline      = fw ? mem_rec_cacheline : line_q[l_idx][w];
            e_valid[w] = fw || valid_q[l_idx][w];
            hit_vec[w] = e_valid[w] && ((fw ? f_tag : tag_q[l_idx][w]) == l_tag);
            if (hit_vec[w]) hit_word = wline[WORD_W * int'(wsel) +: WORD_W];
        end
        hit = |hit_vec;
`ifdef ICACHE_PLRU_EN
        f_rep   = rep_touch(rep_q[f_idx], f_way);
        e_rep   = same ? f_rep : rep_q[l_idx];
        hit_way = '0;
        for (int w = 0; w < N_WAYS; w++) if (hit_vec[w]) hit_way = WAY_W'(w);
        h_rep   = rep_touch(e_rep, hit_way);
        victim  = rep_victim(e_rep);
`else
        f_rep   = (N_WAYS > 1) ? rep_q[f_idx] + 1'b1 : '0;
        e_rep   = same ? f_rep : rep_q[l_idx];
        victim  = e_rep;
`endif
        found = 1'b0;
        for (int w = 0; w < N_WAYS; w++) begin
            if (!found && !e_valid[w]) begin
                victim = WAY_W'(w);
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss         <= 1'b0;
            data         <= '0;
            mem_req_ren  <= 1'b0;
            mem_req_addr <= '0;
            stalled      <= '0;
            pend_q       <= '0;
            for (int s = 0; s < N_SETS; s++) begin
                valid_q[s]   <= '0;
                req_tag_q[s] <= '0;
                req_way_q[s] <= '0;
                rep_q[s]     <= '0;
                for (int w = 0; w < N_WAYS; w++) tag_q[s][w] <= '0;
            end
            for (int t = 0; t < N_THREADS; t++) lis_set_q[t] <= '0;
        end else begin
            miss        <= 1'b0;
            mem_req_ren <= 1'b0;
            if (fill_ok) begin
                valid_q[f_idx][f_way] <= 1'b1;
                tag_q[f_idx][f_way]   <= f_tag;
                pend_q[f_idx]         <= 1'b0;
                rep_q[f_idx]          <= f_rep;
                for (int t = 0; t < N_THREADS; t++)
                    if (stalled[t] && lis_set_q[t] == f_idx) stalled[t] <= 1'b0;
            end
            // Lookup updates come after the fill so a fresh stall on the same thread wins.
            if (!itlb_miss) begin
                if (hit) begin
                    data <= hit_word;
`ifdef ICACHE_PLRU_EN
                    rep_q[l_idx] <= h_rep;
`endif
                end else begin
                    miss <= 1'b1;
                    if (!e_pend) begin
                        mem_req_ren       <= 1'b1;
                        mem_req_addr      <= paddr;
                        pend_q[l_idx]     <= 1'b1;
                        req_tag_q[l_idx]  <= l_tag;
                        req_way_q[l_idx]  <= victim;
                        stalled[thread]   <= 1'b1;
                        lis_set_q[thread] <= l_idx;
                    end else if (req_tag_q[l_idx] == l_tag) begin
                        stalled[thread]   <= 1'b1;
                        lis_set_q[thread] <= l_idx;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_ok) line_q[f_idx][f_way] <= mem_rec_cacheline;
    end

    always @(posedge clk) begin
        if (!rst && !itlb_miss) assert ($onehot0(hit_vec));
    end
endmodule

// File: tb/tb_icache_setassoc.sv
// Scoreboard bench for icache_setassoc: a behavioural cache model predicts each cycle's outputs,
// a monitor compares them one clock later. Directed scenarios followed by random traffic.
module tb_icache_setassoc;
    localparam int N_WAYS = 2, N_SETS = 4, N_THREADS = 4, LINE_WORDS = 4, WORD_W = 32, ADDR_W = 20;
    localparam int LINE_W = LINE_WORDS * WORD_W;
    localparam int LINE_BYTES = LINE_W / 8;
    localparam int WORD_BYTES = WORD_W / 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [1:0]           thread = '0;
    logic [ADDR_W-1:0]    paddr = '0;
    logic                 itlb_miss = 1'b1;
    logic                 miss;
    logic [WORD_W-1:0]    data;
    logic                 mem_rec_en = 1'b0;
    logic [ADDR_W-1:0]    mem_rec_addr = '0;
    logic [LINE_W-1:0]    mem_rec_cacheline = '0;
    logic                 mem_req_ren;
    logic [ADDR_W-1:0]    mem_req_addr;
    logic [N_THREADS-1:0] stalled;

    always #5 clk = ~clk;

    icache_setassoc #(.N_WAYS(N_WAYS), .N_SETS(N_SETS), .N_THREADS(N_THREADS),
                      .LINE_WORDS(LINE_WORDS), .WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .thread(thread), .paddr(paddr), .itlb_miss(itlb_miss),
        .miss(miss), .data(data), .mem_rec_en(mem_rec_en), .mem_rec_addr(mem_rec_addr),
        .mem_rec_cacheline(mem_rec_cacheline), .mem_req_ren(mem_req_ren),
        .mem_req_addr(mem_req_addr), .stalled(stalled));

    typedef struct {
        bit                   miss;
        bit                   ren;
        int                   addr;
        logic [N_THREADS-1:0] stl;
        bit                   chk_data;
        logic [WORD_W-1:0]    data;
    } exp_t;
    exp_t sb[$];
    int checks = 0, errors = 0;

    // Reference model: cache contents as tag/word arrays, recency as access timestamps.
    bit                   m_vld  [N_SETS][N_WAYS];
    int                   m_tag  [N_SETS][N_WAYS];
    logic [WORD_W-1:0]    m_word [N_SETS][N_WAYS][LINE_WORDS];
    int                   m_last [N_SETS][N_WAYS];
    bit                   m_pend [N_SETS];
    int                   m_rtag [N_SETS];
    int                   m_rway [N_SETS];
    int                   m_rr   [N_SETS];
    int                   m_lset [N_THREADS];
    logic [N_THREADS-1:0] m_stall;
    logic [WORD_W-1:0]    m_data;
    bit                   m_known;
    int                   m_time;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < N_SETS; s++) begin
            m_pend[s] = 0; m_rtag[s] = 0; m_rway[s] = 0; m_rr[s] = 0;
            for (int w = 0; w < N_WAYS; w++) begin
                m_vld[s][w] = 0; m_tag[s][w] = 0; m_last[s][w] = 0;
            end
        end
        for (int t = 0; t < N_THREADS; t++) m_lset[t] = 0;
        m_stall = '0; m_data = '0; m_known = 1; m_time = 0;
    endfunction

    function automatic void touch(input int s, input int w);
        m_time++;
        m_last[s][w] = m_time;
    endfunction

    function automatic int pick_victim(input int s);
        int v;
        for (int w = 0; w < N_WAYS; w++) if (!m_vld[s][w]) return w;
`ifdef ICACHE_PLRU_EN
        v = 0;
        for (int w = 1; w < N_WAYS; w++) if (m_last[s][w] < m_last[s][v]) v = w;
`else
        v = m_rr[s];
`endif
        return v;
    endfunction

    // Fill is applied first, then the lookup sees the updated cache.
    function automatic void model_step(input bit lk, input int th, input int a, input bit fe,
                                       input int fa, input logic [LINE_W-1:0] ln);
        exp_t e;
        int fs, ft, s, tg, hw, w;
        fs = (fa / LINE_BYTES) % N_SETS;
        ft = (fa / LINE_BYTES) / N_SETS;
        if (fe && m_pend[fs] && m_rtag[fs] == ft) begin
            w = m_rway[fs];
            m_vld[fs][w] = 1;
            m_tag[fs][w] = ft;
            for (int i = 0; i < LINE_WORDS; i++) m_word[fs][w][i] = ln[i*WORD_W +: WORD_W];
            m_pend[fs] = 0;
            touch(fs, w);
            m_rr[fs] = (m_rr[fs] + 1) % N_WAYS;
            for (int t = 0; t < N_THREADS; t++) if (m_stall[t] && m_lset[t] == fs) m_stall[t] = 1'b0;
        end
        e.miss = 0; e.ren = 0; e.addr = 0;
        if (lk) begin
            s  = (a / LINE_BYTES) % N_SETS;
            tg = (a / LINE_BYTES) / N_SETS;
            hw = -1;
            for (int k = 0; k < N_WAYS; k++) if (m_vld[s][k] && m_tag[s][k] == tg) hw = k;
            if (hw >= 0) begin
                m_data  = m_word[s][hw][(a % LINE_BYTES) / WORD_BYTES];
                m_known = 1;
                touch(s, hw);
            end else begin
                e.miss  = 1;
                m_known = 0;
                if (!m_pend[s]) begin
                    e.ren = 1; e.addr = a;
                    m_pend[s] = 1; m_rtag[s] = tg; m_rway[s] = pick_victim(s);
                    m_stall[th] = 1'b1; m_lset[th] = s;
                end else if (m_rtag[s] == tg) begin
                    m_stall[th] = 1'b1; m_lset[th] = s;
                end
            end
        end
        e.stl = m_stall; e.chk_data = m_known; e.data = m_data;
        sb.push_back(e);
    endfunction

    task automatic cyc(input bit lk, input int th, input int a, input bit fe, input int fa,
                       input logic [LINE_W-1:0] ln);
        @(negedge clk);
        itlb_miss = !lk; thread = 2'(th); paddr = ADDR_W'(a);
        mem_rec_en = fe; mem_rec_addr = ADDR_W'(fa); mem_rec_cacheline = ln;
        model_step(lk, th, a, fe, fa, ln);
    endtask

    task automatic look(input int th, input int a);
        cyc(1, th, a, 0, 0, '0);
    endtask

    task automatic fill(input int fa, input logic [LINE_W-1:0] ln);
        cyc(0, 0, 0, 1, fa, ln);
    endtask

    function automatic logic [LINE_W-1:0] rnd_line();
        logic [LINE_W-1:0] ln;
        for (int i = 0; i < LINE_WORDS; i++) ln[i*WORD_W +: WORD_W] = $urandom;
        return ln;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; itlb_miss = 1'b1; mem_rec_en = 1'b0;
        #1;
        chk("rst_miss", miss, 0);
        chk("rst_data", data, 0);
        chk("rst_ren", mem_req_ren, 0);
        chk("rst_req_addr", mem_req_addr, 0);
        chk("rst_stalled", stalled, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: one expected entry per driven cycle, compared just after the edge that registers it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && sb.size() > 0) begin
                e = sb.pop_front();
                chk("miss", miss, e.miss);
                chk("mem_req_ren", mem_req_ren, e.ren);
                if (e.ren) chk("mem_req_addr", mem_req_addr, e.addr);
                chk("stalled", stalled, e.stl);
                if (e.chk_data) chk("data", data, e.data);
            end
        end
    end

    initial begin
        logic [LINE_W-1:0] ln;
        int a, fa, s, r;
        bit lk, fe;

        // Cold miss, fill, re-lookup of word 2.
        do_reset();
        look(1, 'h00040);
        ln = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
        fill('h00040, ln);
        look(1, 'h00048);
        cyc(0, 0, 0, 0, 0, '0);
        look(2, 'h0004C);

        // Two tags share set 0, then a third evicts by replacement policy.
        do_reset();
        look(0, 'h00000); fill('h00000, rnd_line());
        look(0, 'h00400); fill('h00400, rnd_line());
        look(1, 'h00004); look(1, 'h00408); look(2, 'h00400); look(2, 'h0000C);
        look(3, 'h00800); fill('h00800, rnd_line());
        look(3, 'h00000); look(3, 'h00400); look(3, 'h00804);

        // Shared miss, conflicting-tag retry, fill bypass.
        do_reset();
        look(0, 'h00100);
        look(2, 'h00100);
        look(3, 'h00500);
        cyc(1, 1, 'h00104, 1, 'h00100, rnd_line());
        look(3, 'h00108);

        // Reset while pending: later fill ignored, lookup re-requests.
        do_reset();
        look(0, 'h00100);
        look(2, 'h00100);
        do_reset();
        fill('h00100, rnd_line());
        look(0, 'h00100);
        fill('h00100, rnd_line());
        look(0, 'h00100);

        // Random traffic over a small tag range to force conflicts and hits.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            lk = ($urandom_range(0, 9) < 7);
            a  = (($urandom_range(0, 5) * N_SETS + $urandom_range(0, N_SETS - 1)) * LINE_BYTES)
                 + $urandom_range(0, LINE_WORDS - 1) * WORD_BYTES;
            fe = 0; fa = 0;
            r  = $urandom_range(0, 9);
            if (r < 4) begin
                s = $urandom_range(0, N_SETS - 1);
                if (m_pend[s]) begin
                    fe = 1;
                    fa = (m_rtag[s] * N_SETS + s) * LINE_BYTES;
                end
            end else if (r == 4) begin
                fe = 1;
                fa = ($urandom_range(0, 5) * N_SETS + $urandom_range(0, N_SETS - 1)) * LINE_BYTES;
            end
            cyc(lk, $urandom_range(0, N_THREADS - 1), a, fe, fa, rnd_line());
        end

        @(negedge clk);
        itlb_miss = 1'b1; mem_rec_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("scoreboard_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
